// File: rtl/seg7_display_driver_if.sv
// Processor-side write channel of the 7-segment display driver.
interface seg7_display_driver_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  done_pulse;

  // Processor side: issues writes, observes ready/done.
  modport master (output wr_en, output wr_data, input wr_ready, input done_pulse);
  // Driver side: accepts writes, reports ready/done.
  modport slave  (input wr_en, input wr_data, output wr_ready, output done_pulse);
endinterface

// File: rtl/seg7_display_driver.sv
// Binary-to-BCD (double-dabble, one bit per clock) display driver with a
// multiplexed, active-low 7-segment scan and optional leading-zero blanking.
module seg7_display_driver #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_DIGITS    = 5,
  parameter int unsigned REFRESH_DIV   = 4,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  seg7_display_driver_if.slave   bus,
  output logic [6:0]             seg_n,
  output logic [NUM_DIGITS-1:0]  an_n
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic [BCD_W-1:0]      r_digits;
  logic                  r_wr_ready;
  logic                  r_done;
  logic [REF_W-1:0]      r_ref;
  logic [IDX_W-1:0]      r_idx;

  logic [BCD_W-1:0]      w_bcd_adj;
  logic [BCD_W-1:0]      w_bcd_next;
  logic [DATA_WIDTH-1:0] w_bin_next;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [3:0]            w_digit;
  logic                  w_sel_blank;

  assign bus.wr_ready   = r_wr_ready;
  assign bus.done_pulse = r_done;

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
    end
  end

  assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
  assign w_bin_next = {r_bin[DATA_WIDTH-2:0], 1'b0};

  // Write/convert/load sequencer; digit registers load on the edge done_pulse rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_wr_ready <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.wr_en) begin
            r_bin      <= bus.wr_data;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_wr_ready <= 1'b0;
            r_state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            r_digits <= w_bcd_next;
            r_done   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_wr_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_wr_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit are zero.
  always_comb begin
    logic upper_nz;
    upper_nz = 1'b0;
    w_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_nz   = upper_nz | (r_digits[4*i +: 4] != 4'd0);
      w_blank[i] = BLANK_LEADING && (i != 0) && !upper_nz;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    w_digit     = '0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit     = r_digits[4*i +: 4];
        w_sel_blank = w_blank[i];
      end
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  // Scan timer and registered anode/segment drive, updated together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref <= '0;
      r_idx <= '0;
      an_n  <= ~NUM_DIGITS'(1);
      seg_n <= 7'b1000000;
    end else begin
      if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
        r_ref <= '0;
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_ref <= r_ref + REF_W'(1);
      end
      an_n  <= ~(NUM_DIGITS'(1) << r_idx);
      seg_n <= w_sel_blank ? 7'b1111111 : f_seg(w_digit);
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver against a decimal-arithmetic display model.
module tb_seg7_display_driver;

  localparam int unsigned DW = 16;
  localparam int unsigned ND = 5;
  localparam int unsigned RD = 4;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;

  seg7_display_driver_if #(.DATA_WIDTH(DW)) bus ();

  seg7_display_driver #(
    .DATA_WIDTH(DW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned shown  = 0;

  // Model: expected segments for decimal position i of value v.
  function automatic logic [6:0] exp_seg(input int unsigned v, input int i);
    int unsigned p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && v < p) return 7'b1111111;
    return SEG_TAB[(v / p) % 10];
  endfunction

  // Which digit a one-hot active-low anode pattern selects, -1 if malformed.
  function automatic int decode_idx(input logic [ND-1:0] an);
    for (int i = 0; i < ND; i++) begin
      logic [ND-1:0] pat;
      pat = ~(ND'(1) << i);
      if (an === pat) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int idx;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    repeat (3) tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
    checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done_pulse); end
    checks++; if (an_n !== 5'b11110) begin errors++; $display("FAIL reset_an got %b exp 11110", an_n); end
    checks++; if (seg_n !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b exp 1000000", seg_n); end
    reset = 1'b0;
    shown = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      idx = decode_idx(an_n);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL reset_scan_an got %b", an_n); end
      else if (seg_n !== exp_seg(0, idx)) begin
        errors++; $display("FAIL reset_scan_seg digit %0d got %b exp %b", idx, seg_n, exp_seg(0, idx));
      end
    end
  endtask

  // One write with full latency, ready, and old/new display checks.
  task automatic do_write(input int unsigned v);
    int          idx;
    int unsigned exp_v;
    bus.wr_en = 1'b1;
    bus.wr_data = DW'(v);
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop v=%0d got %b exp 0", v, bus.wr_ready); end
    for (int k = 1; k <= DW + 21; k++) begin
      tick();
      checks++;
      if (bus.done_pulse !== (k == DW)) begin
        errors++; $display("FAIL done_timing v=%0d k=%0d got %b exp %b", v, k, bus.done_pulse, (k == DW));
      end
      checks++;
      if (bus.wr_ready !== (k >= DW + 1)) begin
        errors++; $display("FAIL wr_ready_timing v=%0d k=%0d got %b exp %b", v, k, bus.wr_ready, (k >= DW + 1));
      end
      exp_v = (k >= DW + 1) ? v : shown;
      idx = decode_idx(an_n);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL write_scan_an v=%0d got %b", v, an_n); end
      else if (seg_n !== exp_seg(exp_v, idx)) begin
        errors++; $display("FAIL write_scan_seg v=%0d k=%0d digit %0d got %b exp %b", v, k, idx, seg_n, exp_seg(exp_v, idx));
      end
    end
    shown = v;
  endtask

  task automatic test_known_values();
    do_write(12345);
    do_write(65535);
    do_write(0);
  endtask

  task automatic test_refresh_timing();
    logic [ND-1:0] prev;
    logic [ND-1:0] exp_an;
    int            idx0;
    bit            found;
    found = 1'b0;
    prev = an_n;
    for (int c = 0; c < 3 * RD && !found; c++) begin
      tick();
      if (an_n !== prev) found = 1'b1;
      else prev = an_n;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL refresh_change no anode change seen, got %b", an_n); end
    else begin
      idx0 = decode_idx(an_n);
      for (int j = 0; j < 2 * ND * RD; j++) begin
        exp_an = ~(ND'(1) << ((idx0 + j / RD) % ND));
        checks++;
        if (an_n !== exp_an) begin errors++; $display("FAIL refresh_hold j=%0d got %b exp %b", j, an_n, exp_an); end
        tick();
      end
    end
  endtask

  task automatic test_ignored_write();
    int dones;
    int done_at;
    int idx;
    dones = 0;
    done_at = -1;
    bus.wr_en = 1'b1; bus.wr_data = DW'(100);
    tick();
    bus.wr_en = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = DW'(999);
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b exp 0", bus.wr_ready); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done_pulse === 1'b1) begin dones++; if (done_at < 0) done_at = k; end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", dones); end
    checks++; if (done_at !== DW - 2) begin errors++; $display("FAIL ignore_done_time got %0d exp %0d", done_at, DW - 2); end
    shown = 100;
    for (int c = 0; c < 25; c++) begin
      tick();
      idx = decode_idx(an_n);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL ignore_scan_an got %b", an_n); end
      else if (seg_n !== exp_seg(100, idx)) begin
        errors++; $display("FAIL ignore_scan_seg digit %0d got %b exp %b", idx, seg_n, exp_seg(100, idx));
      end
    end
  endtask

  task automatic test_back_to_back(input int unsigned a, input int unsigned b);
    int done_at;
    int idx;
    done_at = -1;
    bus.wr_en = 1'b1; bus.wr_data = DW'(a);
    tick();
    bus.wr_en = 1'b0;
    repeat (DW) tick();
    checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", bus.done_pulse); end
    bus.wr_en = 1'b1; bus.wr_data = DW'(b);
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle_write got wr_ready %b exp 1", bus.wr_ready); end
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got wr_ready %b exp 0", bus.wr_ready); end
    shown = a;
    for (int k = 1; k <= DW + 4; k++) begin
      tick();
      if (bus.done_pulse === 1'b1 && done_at < 0) done_at = k;
    end
    checks++; if (done_at !== DW) begin errors++; $display("FAIL b2b_second_done got %0d exp %0d", done_at, DW); end
    shown = b;
    for (int c = 0; c < 25; c++) begin
      tick();
      idx = decode_idx(an_n);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL b2b_scan_an got %b", an_n); end
      else if (seg_n !== exp_seg(b, idx)) begin
        errors++; $display("FAIL b2b_scan_seg digit %0d got %b exp %b", idx, seg_n, exp_seg(b, idx));
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int idx;
    dones = 0;
    bus.wr_en = 1'b1; bus.wr_data = DW'(40000);
    tick();
    bus.wr_en = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.wr_ready); end
    checks++; if (an_n !== 5'b11110 || seg_n !== 7'b1000000) begin
      errors++; $display("FAIL midrst_display got an %b seg %b exp 11110 1000000", an_n, seg_n);
    end
    repeat (2) tick();
    reset = 1'b0;
    shown = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done_pulse === 1'b1) dones++;
      idx = decode_idx(an_n);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL midrst_scan_an got %b", an_n); end
      else if (seg_n !== exp_seg(0, idx)) begin
        errors++; $display("FAIL midrst_scan_seg digit %0d got %b exp %b", idx, seg_n, exp_seg(0, idx));
      end
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", dones); end
    do_write(7);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      do_write($urandom_range(0, 65535));
      if (($urandom & 1) == 1) tick();
    end
    do_write($urandom_range(0, 9));
    do_write($urandom_range(10, 99));
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_known_values();
    test_refresh_timing();
    test_ignored_write();
    test_back_to_back(321, 54321);
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
